// File: rtl/pio_in_debounced_if.sv
// Avalon-MM slave bus for the debounced input PIO: 2-bit word address,
// active-low write strobe, 32-bit data paths with registered read data.
interface pio_in_debounced_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/pio_in_debounced.sv
// Debounced Avalon-MM input PIO for board switches and keys.
// Each channel is synchronised through two flops, then debounced by a
// 16-bit counter that must see the synchronised value differ from the
// accepted (stable) value for DEBOUNCE consecutive cycles. Accepted
// changes raise edge events (polarity selectable) into a W1C capture
// register; the interrupt is driven either from stable data or captures.
module pio_in_debounced #(
  parameter int WIDTH     = 18,
  parameter int DEBOUNCE  = 1000,
  parameter int EDGE_TYPE = 2,
  parameter int IRQ_TYPE  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pio_in_debounced_if.slave    bus,
  input  logic [WIDTH-1:0]     in_port,
  output logic                 irq
);

  // Counter value at which a pending change is accepted; the counter
  // clears there, so it never reaches DEBOUNCE and never wraps.
  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] stable;
  logic [15:0]      cnt [WIDTH];
  logic [WIDTH-1:0] differ;
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] evt;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] clr;
  logic             wr_en;
  logic [31:0]      rd_mux;

  // Register writes only use the low WIDTH data bits; the rest are
  // deliberately discarded.
  logic unused_writedata;
  assign unused_writedata = ^bus.writedata;

  // Two-flop synchroniser for the asynchronous board inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1   <= '0;
      sync <= '0;
    end else begin
      s1   <= in_port;
      sync <= s1;
    end
  end

  // Per-channel acceptance and event qualification. An event fires on
  // the very edge the stable value flips, filtered by edge polarity
  // using the new (synchronised) level.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    assign differ[gi] = sync[gi] ^ stable[gi];
    assign accept[gi] = differ[gi] && (cnt[gi] == CNT_LAST);
    assign evt[gi]    = accept[gi] &&
                        ((EDGE_TYPE == 2) ||
                         ((EDGE_TYPE == 0) &&  sync[gi]) ||
                         ((EDGE_TYPE == 1) && !sync[gi]));
  end

  // Debounce counters and accepted values; reset discards partial counts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      // An accepted bit always differs from sync, so flipping it adopts sync.
      stable <= stable ^ accept;
      for (int i = 0; i < WIDTH; i++) begin
        if (!differ[i] || accept[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 16'd1;
        end
      end
    end
  end

  assign wr_en = bus.chipselect && !bus.write_n;
  assign clr   = (wr_en && (bus.address == 2'd3)) ? bus.writedata[WIDTH-1:0] : '0;

  // Interrupt mask and edge capture; a same-cycle event beats a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      if (wr_en && (bus.address == 2'd2)) begin
        irq_mask <= bus.writedata[WIDTH-1:0];
      end
      edge_capture <= (edge_capture & ~clr) | evt;
    end
  end

  // Read mux, zero-extended above WIDTH.
  always_comb begin
    rd_mux = '0;
    case (bus.address)
      2'd0:    rd_mux[WIDTH-1:0] = stable;
      2'd1:    rd_mux[WIDTH-1:0] = sync;
      2'd2:    rd_mux[WIDTH-1:0] = irq_mask;
      default: rd_mux[WIDTH-1:0] = edge_capture;
    endcase
  end

  // Read data is sampled every cycle, independent of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
    end else begin
      bus.readdata <= rd_mux;
    end
  end

  // Interrupt comes straight from registers so it cannot glitch mid-cycle.
  if (IRQ_TYPE == 0) begin : g_irq_level
    assign irq = |(stable & irq_mask);
  end else begin : g_irq_edge
    assign irq = |(edge_capture & irq_mask);
  end

endmodule

// File: tb/tb_pio_in_debounced.sv
// Directed bench for pio_in_debounced. Four instances with DEBOUNCE=8:
// a = any-edge / edge irq, r = rising, f = falling (all WIDTH=18),
// l = WIDTH=4 level irq. Inputs change 1 ns after a rising edge; a change
// applied after edge E-1 reaches stable at edge E9 (the 10th edge).
module tb_pio_in_debounced;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  cs;
  logic [17:0] p18;
  logic [3:0]  pl;
  logic        irq_a, irq_r, irq_f, irq_l;
  int          n_cmp;
  int          n_bad;

  pio_in_debounced_if bus_a ();
  pio_in_debounced_if bus_r ();
  pio_in_debounced_if bus_f ();
  pio_in_debounced_if bus_l ();

  assign bus_a.address = address;  assign bus_a.write_n = write_n;
  assign bus_a.writedata = writedata;  assign bus_a.chipselect = cs[0];
  assign bus_r.address = address;  assign bus_r.write_n = write_n;
  assign bus_r.writedata = writedata;  assign bus_r.chipselect = cs[1];
  assign bus_f.address = address;  assign bus_f.write_n = write_n;
  assign bus_f.writedata = writedata;  assign bus_f.chipselect = cs[2];
  assign bus_l.address = address;  assign bus_l.write_n = write_n;
  assign bus_l.writedata = writedata;  assign bus_l.chipselect = cs[3];

  pio_in_debounced #(.WIDTH(18), .DEBOUNCE(8), .EDGE_TYPE(2), .IRQ_TYPE(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a), .in_port(p18), .irq(irq_a));
  pio_in_debounced #(.WIDTH(18), .DEBOUNCE(8), .EDGE_TYPE(0), .IRQ_TYPE(1)) dut_r (
    .clk(clk), .reset_n(reset_n), .bus(bus_r), .in_port(p18), .irq(irq_r));
  pio_in_debounced #(.WIDTH(18), .DEBOUNCE(8), .EDGE_TYPE(1), .IRQ_TYPE(1)) dut_f (
    .clk(clk), .reset_n(reset_n), .bus(bus_f), .in_port(p18), .irq(irq_f));
  pio_in_debounced #(.WIDTH(4), .DEBOUNCE(8), .EDGE_TYPE(2), .IRQ_TYPE(0)) dut_l (
    .clk(clk), .reset_n(reset_n), .bus(bus_l), .in_port(pl), .irq(irq_l));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a);
    address = a;
    tick(1);
  endtask

  task automatic wr(input logic [3:0] m, input logic [1:0] a, input logic [31:0] d);
    cs        = m;
    address   = a;
    writedata = d;
    write_n   = 1'b0;
    tick(1);
    cs      = 4'b0000;
    write_n = 1'b1;
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    reset_n   = 1'b0;
    address   = 2'd0;
    write_n   = 1'b1;
    writedata = 32'h0;
    cs        = 4'b0000;
    p18       = '1;
    pl        = 4'h0;

    // Reset held with inputs high.
    tick(3);
    check("rst_rdata_a", bus_a.readdata, 32'h0);
    check("rst_irq_a", {31'b0, irq_a}, 32'h0);
    check("rst_rdata_l", bus_l.readdata, 32'h0);
    check("rst_irq_l", {31'b0, irq_l}, 32'h0);

    // Release: data visible on readdata one cycle after stable at edge 10.
    reset_n = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick(1);
      check($sformatf("rst_release_k%0d", k), bus_a.readdata,
            (k >= 11) ? 32'h3FFFF : 32'h0);
    end
    rd(2'd3);
    check("rst_rise_ec_a", bus_a.readdata, 32'h3FFFF);
    check("rst_rise_ec_r", bus_r.readdata, 32'h3FFFF);
    check("rst_rise_ec_f", bus_f.readdata, 32'h0);
    p18 = '0;
    tick(14);
    wr(4'b0111, 2'd3, 32'hFFFF_FFFF);
    rd(2'd3);
    check("clr_all_ec_a", bus_a.readdata, 32'h0);
    check("clr_all_ec_f", bus_f.readdata, 32'h0);

    // Glitch rejection: 7-cycle pulse on bit 3 must not get through.
    wr(4'b0001, 2'd2, 32'h8);
    rd(2'd2);
    check("mask_a", bus_a.readdata, 32'h8);
    address = 2'd0;
    p18 = 18'h8;
    tick(7);
    p18 = 18'h0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      check($sformatf("glitch7_irq_k%0d", k), {31'b0, irq_a}, 32'h0);
      check($sformatf("glitch7_data_k%0d", k), bus_a.readdata, 32'h0);
    end
    rd(2'd3);
    check("glitch7_ec", bus_a.readdata, 32'h0);

    // 9-cycle pulse: capture sets exactly at edge 10 (8 after sync rises).
    p18 = 18'h8;
    tick(9);
    check("pulse9_irq_early", {31'b0, irq_a}, 32'h0);
    p18 = 18'h0;
    tick(1);
    check("pulse9_irq_set", {31'b0, irq_a}, 32'h1);
    rd(2'd3);
    check("pulse9_ec", bus_a.readdata, 32'h8);
    rd(2'd0);
    check("pulse9_data", bus_a.readdata, 32'h8);
    tick(20);
    wr(4'b0111, 2'd3, 32'hFFFF_FFFF);
    rd(2'd0);
    check("pulse9_data_back", bus_a.readdata, 32'h0);

    // Edge polarity: rise then fall on bit 0.
    p18 = 18'h1;
    tick(14);
    rd(2'd3);
    check("rise_ec_any", bus_a.readdata, 32'h1);
    check("rise_ec_rising", bus_r.readdata, 32'h1);
    check("rise_ec_falling", bus_f.readdata, 32'h0);
    wr(4'b0111, 2'd3, 32'h1);
    p18 = 18'h0;
    tick(14);
    rd(2'd3);
    check("fall_ec_any", bus_a.readdata, 32'h1);
    check("fall_ec_rising", bus_r.readdata, 32'h0);
    check("fall_ec_falling", bus_f.readdata, 32'h1);
    wr(4'b0111, 2'd3, 32'hFFFF_FFFF);

    // Write-1-to-clear, and event beating a clear on the same edge.
    p18 = 18'h5;
    tick(14);
    rd(2'd3);
    check("w1c_ec_init", bus_a.readdata, 32'h5);
    rd(2'd1);
    check("raw_a", bus_a.readdata, 32'h5);
    wr(4'b0001, 2'd3, 32'h1);
    rd(2'd3);
    check("w1c_bit0", bus_a.readdata, 32'h4);
    p18 = 18'h1;
    tick(9);
    wr(4'b0001, 2'd3, 32'h4);
    rd(2'd3);
    check("w1c_event_wins", bus_a.readdata, 32'h4);
    wr(4'b0001, 2'd3, 32'h4);
    rd(2'd3);
    check("w1c_bit2", bus_a.readdata, 32'h0);
    wr(4'b0001, 2'd0, 32'hFFFF_FFFF);
    rd(2'd0);
    check("data_write_ignored", bus_a.readdata, 32'h1);
    p18 = 18'h0;
    tick(14);
    wr(4'b0111, 2'd3, 32'hFFFF_FFFF);

    // Edge-mode irq with mask 0x2.
    wr(4'b0001, 2'd2, 32'h2);
    p18 = 18'h1;
    for (int k = 0; k < 14; k++) begin
      tick(1);
      check($sformatf("irq_masked_k%0d", k), {31'b0, irq_a}, 32'h0);
    end
    p18 = 18'h3;
    tick(9);
    check("irq_b1_early", {31'b0, irq_a}, 32'h0);
    tick(1);
    check("irq_b1_set", {31'b0, irq_a}, 32'h1);
    rd(2'd3);
    check("irq_b1_ec", bus_a.readdata, 32'h3);
    wr(4'b0001, 2'd3, 32'h2);
    check("irq_cleared", {31'b0, irq_a}, 32'h0);
    rd(2'd3);
    check("irq_ec_after_clr", bus_a.readdata, 32'h1);

    // Level-mode irq on the 4-bit instance, mask 0x8.
    wr(4'b1000, 2'd2, 32'h8);
    pl = 4'h7;
    tick(14);
    check("lvl_masked", {31'b0, irq_l}, 32'h0);
    pl = 4'hF;
    tick(9);
    check("lvl_rise_early", {31'b0, irq_l}, 32'h0);
    tick(1);
    check("lvl_rise", {31'b0, irq_l}, 32'h1);
    rd(2'd1);
    check("lvl_raw", bus_l.readdata, 32'hF);
    rd(2'd0);
    check("lvl_data", bus_l.readdata, 32'hF);
    pl = 4'h0;
    tick(9);
    check("lvl_fall_early", {31'b0, irq_l}, 32'h1);
    tick(1);
    check("lvl_fall", {31'b0, irq_l}, 32'h0);

    // Bits above WIDTH read as zero.
    wr(4'b1001, 2'd2, 32'hFFFF_FFFF);
    rd(2'd2);
    check("mask_width_l", bus_l.readdata, 32'hF);
    check("mask_width_a", bus_a.readdata, 32'h3FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pio_in_debounced.md
# pio_in_debounced

Parametrised Avalon-MM input PIO for board switches and keys. It adds four things to a plain edge-capture PIO:

- per-channel synchronisation and debounce;
- a selectable edge polarity;
- a selectable IRQ mode (level or edge);
- per-bit write-1-to-clear of the edge-capture register.

It sits between the board input pins and the system interconnect, and drives one interrupt line to the CPU.

## Interface
- WIDTH, 18, number of input channels (1..32)
- DEBOUNCE, 1000, consecutive clk cycles a synchronised input must differ from the debounced value before it is accepted (1..65535)
- EDGE_TYPE, 2, edge that sets edge_capture: 0 rising, 1 falling, 2 any
- IRQ_TYPE, 1, 0 level (irq from debounced data), 1 edge (irq from edge_capture)
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- in_port  in  WIDTH  raw asynchronous board inputs
- readdata  out  32  registered read data, zero-extended above WIDTH
- irq  out  1  interrupt request, active high

## Operation
- Register map:
  - 0: data, RO, debounced value.
  - 1: raw, RO, synchronised undebounced value.
  - 2: irq_mask, RW.
  - 3: edge_capture, RW1C.
- Writes to addresses 0 and 1 are ignored. Bits above WIDTH read 0 and are ignored on write.
- Synchronisation: two-flop chain per bit, in_port -> s1 -> sync.
- Debounce: one counter per channel, 16 bits wide, and a stable register per channel. At each clk edge, per bit:
  - if sync == stable: cnt <= 0;
  - else if cnt == DEBOUNCE-1: stable <= sync, cnt <= 0;
  - else: cnt <= cnt+1.
- A glitch shorter than DEBOUNCE cycles never reaches stable.
- Event: a bit's event fires on the same edge its stable value updates, qualified by EDGE_TYPE:
  - rising: sync = 1;
  - falling: sync = 0;
  - any: either value.
- edge_capture[i] is set on its event. A write to address 3 clears every bit i where writedata[i] = 1; other bits are unaffected.
- If a clear and an event hit the same bit in the same cycle, the event wins and the bit stays 1.
- irq:
  - IRQ_TYPE 0: irq = |(stable & irq_mask).
  - IRQ_TYPE 1: irq = |(edge_capture & irq_mask).
  - irq is combinational from registers only, so it is glitch-free relative to clk.
- The read mux is sampled into readdata on every clk edge regardless of chipselect.
- Reset values: all of the following are 0, and irq is therefore 0.
  - readdata
  - s1, sync, stable
  - every cnt
  - irq_mask
  - edge_capture
- Reset asserted mid-count discards the partial count. After release, inputs that are already high take 2+DEBOUNCE cycles to appear in stable and do produce a rising event.

## Timing
- Input change stable before clk edge E0:
  - sync changes at E1;
  - stable and edge_capture change at E1+DEBOUNCE;
  - in IRQ_TYPE 1, irq rises in the same cycle edge_capture sets.
- Read latency is 1 cycle: address presented at edge E is returned on readdata after edge E, i.e. valid for the cycle following E. No wait states.
- Write takes effect at the clk edge where chipselect=1 and write_n=0. A read of the same register in the next cycle returns the new value.
- The counter never wraps, because it resets at DEBOUNCE-1. The minimum accepted pulse width is DEBOUNCE cycles after synchronisation.

## Test plan
- Reset: hold reset_n=0 with in_port=all ones. Required: readdata=0, irq=0. After release, data reads 0x3FFFF only after 2+DEBOUNCE cycles, never earlier.
- Glitch rejection (DEBOUNCE=8): pulse in_port[3] high for 7 cycles -> data and edge_capture stay 0. Pulse it for 9 cycles -> data[3]=1, and edge_capture=0x8 exactly 8 cycles after sync rises.
- EDGE_TYPE 0 vs 1 vs 2: toggle in_port[0] 0->1->0 with long holds. Required edge_capture[0]: set once on the rise, set once on the fall, and set on both transitions, respectively (clear between checks).
- W1C (EDGE_TYPE 2): with edge_capture=0x5, write 0x1 to address 3 -> reads 0x4. Then create an event on bit 2 in the same cycle as a write of 0x4 -> bit 2 remains 1.
- IRQ (IRQ_TYPE 1): with irq_mask=0x2 and an event on bit 0 -> irq stays 0. An event on bit 1 -> irq=1 in the same cycle edge_capture[1] sets. Writing 0x2 to address 3 -> irq=0 on the next cycle.
- IRQ_TYPE 0, WIDTH=4: with irq_mask=0x8, drive in_port=0x8 -> irq=1 after 2+DEBOUNCE cycles. Drive in_port=0x0 -> irq=0 after the same delay. Reads of raw and data are zero above bit 3.
